// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges EX redirects, trap entry and stall sources into the
// PC unit's jump/hold controls, buffering a redirect while fetch is busy.
module pipe_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned TRAP_DRAIN = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        ex_jump_cause_i,
  input  logic [ADDR_W-1:0] ex_jump_from_i,
  input  logic [ADDR_W-1:0] ex_jump_to_i,
  input  logic              trap_req_i,
  input  logic              trap_is_int_i,
  input  logic [ADDR_W-1:0] trap_pc_i,
  input  logic [ADDR_W-1:0] trap_vector_i,
  input  logic              fetch_ready_i,
  input  logic              id_stall_i,
  input  logic              mem_busy_i,
  input  logic              jtag_halt_i,
  output logic [2:0]        jump_cause_o,
  output logic [ADDR_W-1:0] jump_from_addr_o,
  output logic [ADDR_W-1:0] jump_to_addr_o,
  output logic [2:0]        hold_flag_o,
  output logic              flush_o,
  output logic              trap_ack_o,
  output logic              halted_o
);

  localparam int unsigned CAUSE_W = 3;
  localparam int unsigned CNT_W   = (TRAP_DRAIN > 1) ? $clog2(TRAP_DRAIN) : 1;

  localparam logic [CAUSE_W-1:0] CAUSE_NONE = 3'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_INT  = 3'd4;
  localparam logic [CAUSE_W-1:0] CAUSE_EXC  = 3'd5;

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_IF   = 3'd2;
  localparam logic [2:0] HOLD_EX   = 3'd3;
  localparam logic [2:0] HOLD_ALL  = 3'd4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CAUSE_W-1:0]  pend_cause_q, pend_cause_d;
  logic [ADDR_W-1:0]   pend_from_q, pend_from_d;
  logic [ADDR_W-1:0]   pend_to_q, pend_to_d;
  logic [CNT_W-1:0]    drain_cnt_q, drain_cnt_d;
  logic                halted_q;

  logic                ex_req_c;
  logic                trap_over_pend_c;
  logic [CAUSE_W-1:0]  trap_cause_c;
  logic [CAUSE_W-1:0]  cand_cause_c;
  logic [ADDR_W-1:0]   cand_from_c;
  logic [ADDR_W-1:0]   cand_to_c;

  // Candidate redirect: fresh request in RUN (trap first), or the pending
  // entry in PEND unless a trap overrides a buffered EX redirect.
  always_comb begin
    ex_req_c         = ex_jump_cause_i inside {3'd1, 3'd2, 3'd3};
    trap_cause_c     = trap_is_int_i ? CAUSE_INT : CAUSE_EXC;
    trap_over_pend_c = trap_req_i && !pend_cause_q[2];
    cand_cause_c     = CAUSE_NONE;
    cand_from_c      = '0;
    cand_to_c        = '0;
    if (state_q == ST_PEND) begin
      if (trap_over_pend_c) begin
        cand_cause_c = trap_cause_c;
        cand_from_c  = trap_pc_i;
        cand_to_c    = trap_vector_i;
      end else begin
        cand_cause_c = pend_cause_q;
        cand_from_c  = pend_from_q;
        cand_to_c    = pend_to_q;
      end
    end else if (trap_req_i) begin
      cand_cause_c = trap_cause_c;
      cand_from_c  = trap_pc_i;
      cand_to_c    = trap_vector_i;
    end else if (ex_req_c) begin
      cand_cause_c = ex_jump_cause_i;
      cand_from_c  = ex_jump_from_i;
      cand_to_c    = ex_jump_to_i;
    end
  end

  // Next state, pending buffer, drain counter and zero-latency outputs.
  always_comb begin
    state_d          = state_q;
    pend_cause_d     = pend_cause_q;
    pend_from_d      = pend_from_q;
    pend_to_d        = pend_to_q;
    drain_cnt_d      = drain_cnt_q;
    jump_cause_o     = CAUSE_NONE;
    jump_from_addr_o = '0;
    jump_to_addr_o   = '0;
    hold_flag_o      = HOLD_NONE;
    flush_o          = 1'b0;
    trap_ack_o       = 1'b0;

    unique case (state_q)
      ST_RUN, ST_PEND: begin
        if (cand_cause_c == CAUSE_NONE) begin
          // Only reachable in RUN: plain stall arbitration.
          if (jtag_halt_i) begin
            hold_flag_o = HOLD_ALL;
            state_d     = ST_HALT;
          end else if (mem_busy_i) begin
            hold_flag_o = HOLD_EX;
          end else if (!fetch_ready_i) begin
            hold_flag_o = HOLD_IF;
          end else if (id_stall_i) begin
            hold_flag_o = HOLD_PC;
          end
        end else if (fetch_ready_i) begin
          jump_cause_o     = cand_cause_c;
          jump_from_addr_o = cand_from_c;
          jump_to_addr_o   = cand_to_c;
          flush_o          = 1'b1;
          pend_cause_d     = CAUSE_NONE;
          state_d          = ST_RUN;
          if (cand_cause_c[2]) begin
            trap_ack_o = 1'b1;
            if (TRAP_DRAIN != 0) begin
              state_d     = ST_DRAIN;
              drain_cnt_d = CNT_W'(TRAP_DRAIN - 1);
            end
          end
        end else begin
          hold_flag_o  = HOLD_IF;
          pend_cause_d = cand_cause_c;
          pend_from_d  = cand_from_c;
          pend_to_d    = cand_to_c;
          state_d      = ST_PEND;
        end
      end
      ST_DRAIN: begin
        hold_flag_o = HOLD_ALL;
        if (drain_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          drain_cnt_d = drain_cnt_q - CNT_W'(1);
        end
      end
      ST_HALT: begin
        hold_flag_o = HOLD_ALL;
        if (!jtag_halt_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Nothing leaves the block while reset is asserted.
    if (!rst_n) begin
      jump_cause_o     = CAUSE_NONE;
      jump_from_addr_o = '0;
      jump_to_addr_o   = '0;
      hold_flag_o      = HOLD_NONE;
      flush_o          = 1'b0;
      trap_ack_o       = 1'b0;
    end
  end

  // State and buffer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      pend_cause_q <= CAUSE_NONE;
      pend_from_q  <= '0;
      pend_to_q    <= '0;
      drain_cnt_q  <= '0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_cause_q <= pend_cause_d;
      pend_from_q  <= pend_from_d;
      pend_to_q    <= pend_to_d;
      drain_cnt_q  <= drain_cnt_d;
      halted_q     <= (state_d == ST_HALT);
    end
  end

  assign halted_o = halted_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by random traffic, all
// checked each cycle against a transaction-level reference model.
module tb_pipe_ctrl;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned TRAP_DRAIN = 2;

  logic              clk;
  logic              rst_n;
  logic [2:0]        ex_jump_cause_i;
  logic [ADDR_W-1:0] ex_jump_from_i;
  logic [ADDR_W-1:0] ex_jump_to_i;
  logic              trap_req_i;
  logic              trap_is_int_i;
  logic [ADDR_W-1:0] trap_pc_i;
  logic [ADDR_W-1:0] trap_vector_i;
  logic              fetch_ready_i;
  logic              id_stall_i;
  logic              mem_busy_i;
  logic              jtag_halt_i;
  logic [2:0]        jump_cause_o;
  logic [ADDR_W-1:0] jump_from_addr_o;
  logic [ADDR_W-1:0] jump_to_addr_o;
  logic [2:0]        hold_flag_o;
  logic              flush_o;
  logic              trap_ack_o;
  logic              halted_o;

  pipe_ctrl #(.ADDR_W(ADDR_W), .TRAP_DRAIN(TRAP_DRAIN)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_jump_cause_i  (ex_jump_cause_i),
    .ex_jump_from_i   (ex_jump_from_i),
    .ex_jump_to_i     (ex_jump_to_i),
    .trap_req_i       (trap_req_i),
    .trap_is_int_i    (trap_is_int_i),
    .trap_pc_i        (trap_pc_i),
    .trap_vector_i    (trap_vector_i),
    .fetch_ready_i    (fetch_ready_i),
    .id_stall_i       (id_stall_i),
    .mem_busy_i       (mem_busy_i),
    .jtag_halt_i      (jtag_halt_i),
    .jump_cause_o     (jump_cause_o),
    .jump_from_addr_o (jump_from_addr_o),
    .jump_to_addr_o   (jump_to_addr_o),
    .hold_flag_o      (hold_flag_o),
    .flush_o          (flush_o),
    .trap_ack_o       (trap_ack_o),
    .halted_o         (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a buffered redirect (if any), remaining drain cycles,
  // and whether the debugger currently owns the core.
  bit          m_has_pend  = 1'b0;
  logic [2:0]  m_pcause    = 3'd0;
  logic [31:0] m_pfrom     = '0;
  logic [31:0] m_pto       = '0;
  int          m_drain     = 0;
  bit          m_halt      = 1'b0;
  bit          m_last_ack  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: evaluate the model for the current inputs, compare, advance.
  task automatic step();
    logic [2:0]  e_cause, r_cause;
    logic [31:0] e_from, e_to, r_from, r_to;
    logic [2:0]  e_hold;
    bit          e_flush, e_ack, e_halted, have_req, issue;
    e_cause = 3'd0; e_from = '0; e_to = '0; e_hold = 3'd0;
    e_flush = 1'b0; e_ack = 1'b0; e_halted = m_halt;
    r_cause = 3'd0; r_from = '0; r_to = '0; have_req = 1'b0; issue = 1'b0;
    #1;
    if (!rst_n) begin
      m_has_pend = 1'b0; m_drain = 0; m_halt = 1'b0;
    end else if (m_halt) begin
      e_hold = 3'd4;
      if (!jtag_halt_i) m_halt = 1'b0;
    end else if (m_drain > 0) begin
      e_hold = 3'd4;
      m_drain--;
    end else begin
      if (m_has_pend) begin
        have_req = 1'b1;
        if (trap_req_i && m_pcause < 3'd4) begin
          r_cause = trap_is_int_i ? 3'd4 : 3'd5; r_from = trap_pc_i; r_to = trap_vector_i;
        end else begin
          r_cause = m_pcause; r_from = m_pfrom; r_to = m_pto;
        end
      end else if (trap_req_i) begin
        have_req = 1'b1;
        r_cause = trap_is_int_i ? 3'd4 : 3'd5; r_from = trap_pc_i; r_to = trap_vector_i;
      end else if (ex_jump_cause_i >= 3'd1 && ex_jump_cause_i <= 3'd3) begin
        have_req = 1'b1;
        r_cause = ex_jump_cause_i; r_from = ex_jump_from_i; r_to = ex_jump_to_i;
      end
      if (have_req && fetch_ready_i) begin
        issue = 1'b1;
        e_cause = r_cause; e_from = r_from; e_to = r_to; e_flush = 1'b1;
        m_has_pend = 1'b0;
        if (r_cause >= 3'd4) begin
          e_ack = 1'b1;
          m_drain = TRAP_DRAIN;
        end
      end else if (have_req) begin
        e_hold = 3'd2;
        m_has_pend = 1'b1; m_pcause = r_cause; m_pfrom = r_from; m_pto = r_to;
      end else begin
        if (jtag_halt_i)        e_hold = 3'd4;
        else if (mem_busy_i)    e_hold = 3'd3;
        else if (!fetch_ready_i) e_hold = 3'd2;
        else if (id_stall_i)    e_hold = 3'd1;
        if (jtag_halt_i) m_halt = 1'b1;
      end
    end
    m_last_ack = e_ack;
    chk("jump_cause", 32'(jump_cause_o), 32'(e_cause));
    chk("jump_from",  jump_from_addr_o, e_from);
    chk("jump_to",    jump_to_addr_o, e_to);
    chk("hold_flag",  32'(hold_flag_o), 32'(e_hold));
    chk("flush",      32'(flush_o), 32'(e_flush));
    chk("trap_ack",   32'(trap_ack_o), 32'(e_ack));
    chk("halted",     32'(halted_o), 32'(e_halted));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ex_jump_cause_i = 3'd0; ex_jump_from_i = '0; ex_jump_to_i = '0;
    trap_req_i = 1'b0; trap_is_int_i = 1'b0; trap_pc_i = '0; trap_vector_i = '0;
    fetch_ready_i = 1'b1; id_stall_i = 1'b0; mem_busy_i = 1'b0; jtag_halt_i = 1'b0;
  endtask

  initial begin
    int halt_left;
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    // Reset: everything quiet even with a request on the inputs.
    ex_jump_cause_i = 3'd1; ex_jump_to_i = 32'h0000_0444;
    step();
    idle_inputs();
    step();
    rst_n = 1'b1;
    step();

    // Same-cycle EX redirect.
    ex_jump_cause_i = 3'd2; ex_jump_from_i = 32'h0000_0040; ex_jump_to_i = 32'h0000_0100;
    step();
    idle_inputs();
    step();

    // Redirect buffered across three not-ready cycles, issued on the fourth.
    ex_jump_cause_i = 3'd1; ex_jump_from_i = 32'h0000_0080; ex_jump_to_i = 32'h0000_0200;
    fetch_ready_i = 1'b0;
    step();
    ex_jump_cause_i = 3'd0;
    step();
    step();
    fetch_ready_i = 1'b1;
    step();
    step();

    // Trap beats EX; ack pulse then two drain cycles.
    trap_req_i = 1'b1; trap_is_int_i = 1'b0; trap_pc_i = 32'h0000_0300;
    trap_vector_i = 32'h8000_0000;
    ex_jump_cause_i = 3'd3; ex_jump_to_i = 32'h0000_0999;
    step();
    idle_inputs();
    step();
    step();
    step();
    // Interrupt flavour, arriving while fetch is busy.
    trap_req_i = 1'b1; trap_is_int_i = 1'b1; trap_pc_i = 32'h0000_0310;
    trap_vector_i = 32'h8000_0004; fetch_ready_i = 1'b0;
    step();
    fetch_ready_i = 1'b1;
    step();
    idle_inputs();
    step(); step(); step();

    // Stall priority.
    mem_busy_i = 1'b1; id_stall_i = 1'b1;
    step();
    mem_busy_i = 1'b0;
    step();
    idle_inputs();
    step();

    // Halt requested while a redirect is pending.
    ex_jump_cause_i = 3'd1; ex_jump_from_i = 32'h0000_0500; ex_jump_to_i = 32'h0000_0600;
    fetch_ready_i = 1'b0;
    step();
    ex_jump_cause_i = 3'd0; jtag_halt_i = 1'b1;
    step();
    fetch_ready_i = 1'b1;
    step();
    step();
    step();
    step();
    jtag_halt_i = 1'b0;
    step();
    step();

    // Reset while pending: the buffered redirect must vanish.
    ex_jump_cause_i = 3'd2; ex_jump_to_i = 32'h0000_0700; fetch_ready_i = 1'b0;
    step();
    ex_jump_cause_i = 3'd0; rst_n = 1'b0;
    step();
    rst_n = 1'b1; fetch_ready_i = 1'b1;
    step();
    step();

    // Random traffic; trap request held until acknowledged, halt held a while.
    halt_left = 0;
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      ex_jump_cause_i = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      ex_jump_from_i  = $urandom;
      ex_jump_to_i    = $urandom;
      if (m_last_ack) trap_req_i = 1'b0;
      if (!trap_req_i && $urandom_range(0, 19) == 0) begin
        trap_req_i    = 1'b1;
        trap_is_int_i = 1'($urandom_range(0, 1));
        trap_pc_i     = $urandom;
        trap_vector_i = $urandom;
      end
      fetch_ready_i = ($urandom_range(0, 3) != 0);
      id_stall_i    = ($urandom_range(0, 3) == 0);
      mem_busy_i    = ($urandom_range(0, 5) == 0);
      if (halt_left > 0) begin
        halt_left--;
        jtag_halt_i = (halt_left != 0);
      end else if ($urandom_range(0, 49) == 0) begin
        halt_left   = $urandom_range(1, 6);
        jtag_halt_i = 1'b1;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
